// File: rtl/dbg_mon_pkg.sv
// Shared encodings and constants for the debug-monitor dump path.
package dbg_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    localparam int NUM_DBG_REGS = 8;
    localparam int FRAME_CHARS  = 25;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter; txd is registered, first start bit one edge after load.
// ready is high when idle or in the final cycle of a stop bit, so bytes can run back-to-back.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    assign ready = !active || (bit_idx == 4'd9 && cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txd     <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (load && ready) begin
            shreg   <= data;
            txd     <= 1'b0;
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    txd     <= 1'b1;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    txd     <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbg_monitor_tx.sv
// Snapshots the eight debug registers over 8 cycles, then sends them as one ASCII hex line.
// Latency: first start bit 9 edges after start is accepted; done 250*CLKS_PER_BIT edges later.
module dbg_monitor_tx
    import dbg_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_addr,
    input  logic [7:0] dbg_data,
    output logic       txd
);

    localparam logic [4:0] CHAR_END = 5'(FRAME_CHARS);
    localparam logic [4:0] CHAR_CR  = 5'(FRAME_CHARS - 2);
    localparam logic [4:0] CHAR_LF  = 5'(FRAME_CHARS - 1);
    localparam logic [2:0] ADDR_LAST = 3'(NUM_DBG_REGS - 1);

    state_t     state;
    logic [7:0] snap [NUM_DBG_REGS];
    logic [4:0] char_idx;
    logic [2:0] reg_idx;
    logic [1:0] sub_idx;
    logic       uart_ready;
    logic       uart_load;
    logic [7:0] char_dat;
    logic [7:0] sel_reg;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return ASCII_ZERO + {4'd0, n};
        else           return ASCII_A + {4'd0, n - 4'd10};
    endfunction

    // reg_idx/sub_idx track char_idx/3 and char_idx%3 without a divider
    always_comb begin
        sel_reg  = snap[reg_idx];
        char_dat = ASCII_SP;
        if (char_idx == CHAR_CR)      char_dat = ASCII_CR;
        else if (char_idx == CHAR_LF) char_dat = ASCII_LF;
        else if (sub_idx == 2'd0)     char_dat = hex_ascii(sel_reg[7:4]);
        else if (sub_idx == 2'd1)     char_dat = hex_ascii(sel_reg[3:0]);
    end

    assign uart_load = (state == ST_SEND) && (char_idx != CHAR_END);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbg_addr <= '0;
            char_idx <= '0;
            reg_idx  <= '0;
            sub_idx  <= '0;
            for (int i = 0; i < NUM_DBG_REGS; i++) snap[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_CAPTURE;
                        busy     <= 1'b1;
                        dbg_addr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    snap[dbg_addr] <= dbg_data;
                    if (dbg_addr == ADDR_LAST) begin
                        state    <= ST_SEND;
                        dbg_addr <= '0;
                        char_idx <= '0;
                        reg_idx  <= '0;
                        sub_idx  <= '0;
                    end else begin
                        dbg_addr <= dbg_addr + 3'd1;
                    end
                end
                ST_SEND: begin
                    if (uart_ready) begin
                        if (char_idx == CHAR_END) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 5'd1;
                            if (sub_idx == 2'd2) begin
                                sub_idx <= '0;
                                reg_idx <= reg_idx + 3'd1;
                            end else begin
                                sub_idx <= sub_idx + 2'd1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clock(clock),
        .reset(reset),
        .load (uart_load),
        .data (char_dat),
        .txd  (txd),
        .ready(uart_ready)
    );

endmodule

// File: tb/tb_dbg_monitor_tx.sv
// Bench for dbg_monitor_tx: datapath model, UART decoder feeding a byte scoreboard.
module tb_dbg_monitor_tx;

    localparam int CPB = 4;
    localparam int DONE_AT = 9 + 250 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, txd;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_checks = 0;
    int n_err    = 0;
    int dp_mode  = 0;
    int rx_cnt   = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        int    mode;
        string line;
    } vec_t;

    vec_t vecs [4];

    dbg_monitor_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .txd     (txd)
    );

    always #5 clock = ~clock;

    always_comb begin
        dbg_data = 8'h00;
        case (dp_mode)
            0:       dbg_data = (dbg_addr == 3'd7) ? 8'hFF : 8'h10 + {5'd0, dbg_addr};
            1:       dbg_data = 8'hA5;
            2:       dbg_data = {1'b0, dbg_addr, 4'hF - {1'b0, dbg_addr}};
            default: dbg_data = 8'h00;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART decoder: samples each bit near its middle on the falling clock edge
    logic       d_act = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_sh  = 8'h00;

    always @(negedge clock) begin
        if (reset) begin
            d_act <= 1'b0;
        end else if (!d_act) begin
            if (txd == 1'b0) begin
                d_act <= 1'b1;
                d_cnt <= 0;
            end
        end else begin
            d_cnt <= d_cnt + 1;
            if (d_cnt % CPB == 1) begin
                if (d_cnt / CPB == 0) begin
                    check("start_bit", int'(txd), 0);
                end else if (d_cnt / CPB <= 8) begin
                    d_sh[d_cnt / CPB - 1] <= txd;
                end else begin
                    check("stop_bit", int'(txd), 1);
                    rx_cnt <= rx_cnt + 1;
                    d_act  <= 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(d_sh), -1);
                    end else begin
                        check("rx_byte", int'(d_sh), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic run_dump(input int mode, input string line, input int mid_pulse, input int abort_at);
        int rx0, dn, dpos;
        dp_mode = mode;
        for (int i = 0; i < line.len(); i++) exp_q.push_back(line[i]);
        rx0  = rx_cnt;
        dn   = 0;
        dpos = -1;
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < DONE_AT + 300; n++) begin
            @(negedge clock);
            if (n == 0) start = 1'b0;
            if (n == mid_pulse) start = 1'b1;
            if (n == mid_pulse + 1) start = 1'b0;
            if (n == 0) check("busy_rise", int'(busy), 1);
            if (n <= 7) check("dbg_addr_step", int'(dbg_addr), n);
            if (n == 8) begin
                check("dbg_addr_back0", int'(dbg_addr), 0);
                check("txd_before_frame", int'(txd), 1);
            end
            if (n == 9) check("first_start_bit", int'(txd), 0);
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_txd", int'(txd), 1);
                check("abort_busy", int'(busy), 0);
                check("abort_addr", int'(dbg_addr), 0);
                check("abort_rx_partial", rx_cnt - rx0, 5);
                exp_q.delete();
                repeat (3) @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (done) begin
                dn++;
                if (dpos < 0) dpos = n;
            end
        end
        check("done_pulses", dn, 1);
        check("done_cycle", dpos, DONE_AT);
        check("bytes_sent", rx_cnt - rx0, line.len());
        check("scoreboard_empty", exp_q.size(), 0);
        check("idle_after", int'(busy), 0);
    endtask

    initial begin
        int   rx0, dn;
        int   dpos [3];
        logic want_busy;

        vecs[0] = '{0, "10 11 12 13 14 15 16 FF\r\n"};
        vecs[1] = '{1, "A5 A5 A5 A5 A5 A5 A5 A5\r\n"};
        vecs[2] = '{2, "0F 1E 2D 3C 4B 5A 69 78\r\n"};
        vecs[3] = '{3, "00 00 00 00 00 00 00 00\r\n"};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("rst_txd", int'(txd), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_addr", int'(dbg_addr), 0);
        end

        for (int v = 0; v < 4; v++) begin
            check("line_len", vecs[v].line.len(), 25);
            run_dump(vecs[v].mode, vecs[v].line, -1, -1);
        end

        // start pulsed again during char 10 must be ignored
        run_dump(0, vecs[0].line, 9 + 10 * 10 * CPB + 3, -1);

        // reset mid data bit of char 5, then a clean dump
        run_dump(0, vecs[0].line, -1, 9 + 5 * 10 * CPB + 11);
        repeat (5) @(negedge clock);
        run_dump(0, vecs[0].line, -1, -1);

        // start held high: three dumps back-to-back
        dp_mode = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 25; i++) exp_q.push_back(vecs[0].line[i]);
        rx0 = rx_cnt;
        dn = 0;
        want_busy = 1'b0;
        for (int k = 0; k < 3; k++) dpos[k] = -1;
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < 3 * (DONE_AT + 1) + 300; n++) begin
            @(negedge clock);
            if (want_busy) begin
                check("busy_rearm", int'(busy), 1);
                want_busy = 1'b0;
            end
            if (done) begin
                if (dn < 3) dpos[dn] = n;
                dn++;
                check("done_busy_low", int'(busy), 0);
                if (dn >= 3) start = 1'b0;
                else want_busy = 1'b1;
            end
        end
        check("held_done_count", dn, 3);
        check("held_done0", dpos[0], DONE_AT);
        check("held_done1", dpos[1], 2 * DONE_AT + 1);
        check("held_done2", dpos[2], 3 * DONE_AT + 2);
        check("held_bytes", rx_cnt - rx0, 75);
        check("held_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_monitor_tx.md
# dbg_monitor_tx

Debug-monitor reader for the CDECV core: on request it walks the datapath's debug port (`dbg_addr`/`dbg_data`), snapshots all eight observable values (PC, A, B, C, T, R, FLG, Xbus), and transmits them as one ASCII hex line over a UART 8N1 transmitter. It sits beside the datapath at board top level, driving `dbg_addr` and consuming `dbg_data`, and gives a host terminal a register dump without extra board I/O.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `clock` input, 1 bit: system clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: dump request; sampled only in IDLE; level or pulse both accepted.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until the last stop bit completes.
- `done` output, 1 bit: one-cycle pulse when the frame finishes.
- `dbg_addr` output, 3 bits: debug select toward the datapath (0 PC, 1 A, 2 B, 3 C, 4 T, 5 R, 6 FLG, 7 Xbus).
- `dbg_data` input, 8 bits: combinational debug value returned for `dbg_addr`.
- `txd` output, 1 bit: UART serial line, idle high.

## Operation
- Reset values: `txd`=1, `busy`=0, `done`=0, `dbg_addr`=0, state IDLE, all counters 0, snapshot buffer 0.
- States: IDLE -> CAPTURE -> SEND -> IDLE.
- IDLE: `start`=1 moves to CAPTURE on the next edge; `busy` rises on that edge.
- CAPTURE: 8 cycles; in capture cycle k (k=0..7), `dbg_addr`=k and `snap[k]` <= `dbg_data` at the end of the cycle. After k=7, go to SEND with char index 0; `dbg_addr` returns to 0.
- SEND: 25 characters, index 0..24. Register k (0..7) maps to chars 3k (high nibble) and 3k+1 (low nibble). Char 3k+2 for k<7 is space 0x20. Char 23 is CR 0x0D; char 24 is LF 0x0A.
- Nibble-to-ASCII: 0..9 map to 0x30+n; 10..15 map to 0x41+(n-10), uppercase.
- Each char is sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). Each bit lasts `CLKS_PER_BIT` cycles. Chars are back-to-back, with no idle gap between a stop bit and the next start bit.
- After the stop bit of char 24 completes: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` during CAPTURE or SEND is ignored and not queued. `start` held high in the `done` cycle begins a new dump on the following edge.
- Coherence: the snapshot spans 8 consecutive cycles. A consistent dump requires the CPU to be halted or single-stepped, which is the top level's responsibility. This block makes no attempt to freeze the core.
- Reset in any state aborts immediately (asynchronously): `txd` returns to 1 at once, and no partial character completes.

## Timing
- Capture latency: `start` is accepted at edge E0; captures occur at edges E1..E8.
- The first start bit is driven on `txd` from edge E9.
- Frame length: 25 × 10 × `CLKS_PER_BIT` cycles. `done` is asserted at edge E9 + 250·`CLKS_PER_BIT`.
- `txd`, `busy`, `done`, and `dbg_addr` are all registered outputs: no combinational path from inputs.
- Bit counter width: ceil(log2(`CLKS_PER_BIT`)). Char index is 5 bits; bit index is 4 bits.

## Structure
- Shared package/header `dbg_mon_pkg`: state encodings, `NUM_DBG_REGS`=8, `FRAME_CHARS`=25, and ASCII constants SP/CR/LF/'0'/'A'.
- One sub-module, `uart_tx_byte`:
  - Inputs: `clock`, `reset`, `load`, `data[7:0]`.
  - Outputs: `txd`, `ready`.
  - Parameter: `CLKS_PER_BIT`.
  - Owns the start/data/stop bit sequencing.
- The parent owns capture, the snapshot buffer, char selection, and the hex encoder.

## Test plan
Bench uses `CLKS_PER_BIT`=4 and a datapath model returning value 0x10+addr (addr 7 returns 0xFF). A UART decoder checks `txd`.
- Pulse `start` one cycle -> `dbg_addr` steps 0..7 on E1..E8; decoded line is "10 11 12 13 14 15 16 FF\r\n" (25 bytes); `done` pulses once, at cycle E9+1000.
- Model returns 0xA5 for every addr -> every register field decodes as "A5"; checks uppercase and the nibble split.
- `start` held high continuously -> dumps run back-to-back; each new `busy` rises the cycle after `done`; no dump is dropped or overlapped.
- Pulse `start` again mid-SEND (char 10) -> ignored; exactly 25 bytes are sent and one `done` pulse occurs.
- Assert `reset` mid-data-bit of char 5 -> `txd`=1 and `busy`=0 immediately; after release, `start` yields a complete, correct frame.
- Reset values after power-up reset: `txd`=1, `busy`=0, `done`=0, `dbg_addr`=0 for 20 idle cycles with `start`=0.
